gtfraw_wrapper_syncer_bus_tx: RTL and testbench
===============================================

// Module: gtfraw_wrapper_syncer_bus_tx
// PURPOSE
//  Source-domain sender of a two-phase (toggle) req/ack bus-crossing handshake.
//  Captures a WIDTH-bit word and holds it stable, then toggles req_level.
//  The far domain samples req_level through its level syncer, takes data_hold and returns ack_level.
//  This block synchronises ack_level back into its own domain and frees itself for the next word.
// PARAMETERS
//  WIDTH           32    data word width
//  RESET_VALUE     1'b0  per-bit reset value of data_hold (replicated WIDTH times)
//  TIMEOUT_CYCLES  1024  WAIT_ACK cycle limit; used only with GTFRAW_SYNCER_TX_TIMEOUT_EN; >=2
// PORTS
//  clk           in   1      single clock (source domain)
//  reset         in   1      asynchronous, active-low reset
//  in_valid      in   1      word offered on in_data
//  in_data       in   WIDTH  word to cross
//  in_ready      out  1      registered; word accepted at edge where in_valid & in_ready
//  data_hold     out  WIDTH  registered held word, to far domain; stable while busy
//  req_level     out  1      registered toggle request, to far-domain level syncer
//  ack_level_in  in   1      raw ack toggle from far domain (asynchronous)
//  busy          out  1      1 in WAIT_ACK
//  done          out  1      1-cycle pulse: ack matched
//  timeout_err   out  1      1-cycle pulse: ack not returned in time (0 without macro)
// BEHAVIOUR
//  Reset (reset==0, async assert, sync release)
//   - state=IDLE, req_level=0, data_hold={WIDTH{RESET_VALUE}}, ack sync chain=0.
//   - in_ready=0, busy=0, done=0, timeout_err=0; timeout counter=0.
//   - in_ready rises at the first clk edge after release.
//  Ack synchroniser: 3 flops ack_meta->ack_meta2->ack_sync, all ASYNC_REG, reset 0.
//   - ack_level_in stable before edge K appears on ack_sync after edge K+2.
//  States
//   - IDLE
//     - in_ready=1.
//     - On accept at edge N: data_hold<=in_data, req_level<=~req_level.
//     - State->WAIT_ACK, in_ready<=0, busy<=1, counter<=0.
//   - WAIT_ACK
//     - When ack_sync==req_level at an edge: state->IDLE, done<=1 for one cycle.
//     - Same edge: in_ready<=1, busy<=0.
//  Latency: ack_level_in tied to req_level (loopback).
//   - Accept at N -> done and in_ready high after edge N+4; max 1 word per 5 clks.
//  Boundary rules
//   - in_valid while in_ready=0: ignored, no capture, no toggle. in_data is don't-care.
//   - ack_sync changes while IDLE: ignored; no done pulse.
//   - data_hold and req_level change only at an accept edge.
//   - done coincident with in_valid: the new word is accepted only from the next cycle (in_ready registered).
//   - Reset mid-transfer: pending word dropped, req_level returns to 0.
//     Far side must be reset together with this block.
// CONFIGURATION
//  GTFRAW_SYNCER_TX_TIMEOUT_EN defined
//   - Counter width $clog2(TIMEOUT_CYCLES+1); increments each WAIT_ACK cycle without match.
//   - On the edge where counter==TIMEOUT_CYCLES-1 with no match:
//     - state->IDLE, timeout_err<=1 (one cycle), in_ready<=1, busy<=0.
//     - req_level is kept unchanged.
//   - Match and limit at the same edge: match wins (done=1, timeout_err=0).
//   - A late ack after timeout is ignored in IDLE.
//  Not defined
//   - WAIT_ACK waits indefinitely, no counter logic.
//   - timeout_err tied 0; TIMEOUT_CYCLES unused.
// TESTING
//  1. Reset check.
//     - Stimulus: hold reset=0 while driving in_valid=1.
//     - Response: in_ready=0, req_level=0, data_hold=0; in_ready=1 one edge after release.
//  2. Loopback single word.
//     - Stimulus: ack_level_in=req_level; send 32'hA5A5_0001 at edge N.
//     - Response: req_level 0->1 after N; done pulse and in_ready=1 after N+4; data_hold=32'hA5A5_0001.
//  3. Loopback back-to-back.
//     - Stimulus: in_valid held high for 4 words 1,2,3,4.
//     - Response: req_level toggles 4 times 5 clks apart; 4 done pulses; data_hold ends at 4; no word lost or duplicated.
//  4. Busy protection.
//     - Stimulus: ack withheld 20 clks after accepting 32'h1; in_valid=1 with 32'hDEAD throughout.
//     - Response: data_hold stays 32'h1; req_level toggles once.
//  5. Mid-transfer reset.
//     - Stimulus: assert reset 2 clks after accept.
//     - Response: req_level=0, busy=0, no done pulse; a normal transfer succeeds after release.
//  6. Timeout (macro on, TIMEOUT_CYCLES=8).
//     - Stimulus: ack never returns.
//     - Response: timeout_err pulses exactly 8 clks after accept; in_ready=1; done never pulses.

Source files
------------

// File: rtl/gtfraw_wrapper_syncer_bus_tx.sv
// Source-domain sender of a two-phase req/ack handshake: holds a word, toggles req_level, waits for ack_level.
// Optional WAIT_ACK timeout is enabled by defining GTFRAW_SYNCER_TX_TIMEOUT_EN.
module gtfraw_wrapper_syncer_bus_tx #(
  parameter int unsigned WIDTH          = 32,
  parameter logic        RESET_VALUE    = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_hold,
  output logic             req_level,
  input  logic             ack_level_in,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic {IDLE, WAIT_ACK} state_t;

  state_t           state_q, state_d;
  logic             in_ready_d, busy_d, done_d, req_d;
  logic [WIDTH-1:0] data_d;
  logic             accept_c;

  (* ASYNC_REG = "TRUE" *) logic ack_meta;
  (* ASYNC_REG = "TRUE" *) logic ack_meta2;
  (* ASYNC_REG = "TRUE" *) logic ack_sync;

  assign accept_c = in_valid & in_ready;

  // Three-flop synchroniser for the far-domain ack toggle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ack_meta  <= 1'b0;
      ack_meta2 <= 1'b0;
      ack_sync  <= 1'b0;
    end else begin
      ack_meta  <= ack_level_in;
      ack_meta2 <= ack_meta;
      ack_sync  <= ack_meta2;
    end
  end

`ifdef GTFRAW_SYNCER_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      timeout_err <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      timeout_err <= timeout_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_level <= 1'b0;
      data_hold <= {WIDTH{RESET_VALUE}};
    end else begin
      state_q   <= state_d;
      in_ready  <= in_ready_d;
      busy      <= busy_d;
      done      <= done_d;
      req_level <= req_d;
      data_hold <= data_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    in_ready_d = in_ready;
    busy_d     = busy;
    done_d     = 1'b0;
    req_d      = req_level;
    data_d     = data_hold;
`ifdef GTFRAW_SYNCER_TX_TIMEOUT_EN
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
        if (accept_c) begin
          data_d     = in_data;
          req_d      = ~req_level;
          state_d    = WAIT_ACK;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef GTFRAW_SYNCER_TX_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      WAIT_ACK: begin
        in_ready_d = 1'b0;
        busy_d     = 1'b1;
        if (ack_sync == req_level) begin
          state_d    = IDLE;
          done_d     = 1'b1;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
`ifdef GTFRAW_SYNCER_TX_TIMEOUT_EN
        // A match on the limit edge takes priority over the timeout
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d    = IDLE;
          timeout_d  = 1'b1;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gtfraw_wrapper_syncer_bus_tx.sv
// Randomised self-checking bench for gtfraw_wrapper_syncer_bus_tx against a transaction-level model.
module tb_gtfraw_wrapper_syncer_bus_tx;
  localparam int unsigned W  = 32;
  localparam int unsigned TO = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, req_level, ack_level_in, busy, done, timeout_err;
  logic [W-1:0] in_data, data_hold;
  logic         loopback, ack_force;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_cnt = 0, to_cnt = 0, tog_cnt = 0;
  logic req_prev = 1'b0;

  logic         exp_req;
  logic [W-1:0] exp_hold;

  assign ack_level_in = loopback ? req_level : ack_force;

  gtfraw_wrapper_syncer_bus_tx #(.WIDTH(W), .RESET_VALUE(1'b0), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .data_hold(data_hold), .req_level(req_level), .ack_level_in(ack_level_in),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (timeout_err === 1'b1) to_cnt <= to_cnt + 1;
    if (req_level !== req_prev) tog_cnt <= tog_cnt + 1;
    req_prev <= req_level;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0; in_valid = 1'b1; in_data = $urandom; loopback = 1'b1; ack_force = 1'b0;
    repeat (3) tick;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    n_cmp++; if (req_level !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b exp 0", req_level); end
    n_cmp++; if (data_hold !== '0) begin n_bad++; $display("FAIL reset_hold got %h exp 0", data_hold); end
    n_cmp++; if ({busy, done, timeout_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b exp 000", {busy, done, timeout_err}); end
    in_valid = 1'b0; reset = 1'b1;
    tick;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready got %b exp 1", in_ready); end
    exp_req = 1'b0; exp_hold = '0;
  endtask

  task automatic test_loopback_single(input logic [W-1:0] w);
    int early;
    loopback = 1'b1; in_valid = 1'b1; in_data = w;
    tick;
    in_valid = 1'b0; exp_req = ~exp_req; exp_hold = w;
    n_cmp++; if (req_level !== exp_req) begin n_bad++; $display("FAIL single_req got %b exp %b", req_level, exp_req); end
    n_cmp++; if (data_hold !== exp_hold) begin n_bad++; $display("FAIL single_hold got %h exp %h", data_hold, exp_hold); end
    n_cmp++; if ({in_ready, busy} !== 2'b01) begin n_bad++; $display("FAIL single_busy got %b exp 01", {in_ready, busy}); end
    early = 0;
    repeat (3) begin tick; if (done !== 1'b0) early++; end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL single_early_done got %0d exp 0", early); end
    tick;
    n_cmp++; if ({done, in_ready, busy} !== 3'b110) begin n_bad++; $display("FAIL single_done got %b exp 110", {done, in_ready, busy}); end
    tick;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_back_to_back(input bit rand_mode, input int n);
    logic [W-1:0] words[$];
    int idx, last, d0, t0;
    logic pre_ready, pre_valid;
    loopback = 1'b1;
    for (int i = 0; i < n; i++) words.push_back(rand_mode ? W'($urandom) : W'(i + 1));
    d0 = done_cnt; t0 = tog_cnt; idx = 0; last = -1;
    in_data = words[0]; in_valid = 1'b1;
    for (int c = 0; c < 200 && idx < n; c++) begin
      pre_ready = in_ready; pre_valid = in_valid;
      tick;
      if (pre_ready && pre_valid) begin
        exp_req = ~exp_req; exp_hold = words[idx];
        n_cmp++; if ({req_level, data_hold} !== {exp_req, exp_hold}) begin n_bad++; $display("FAIL b2b_word%0d got %b/%h exp %b/%h", idx, req_level, data_hold, exp_req, exp_hold); end
        if (last >= 0) begin
          n_cmp++;
          if (rand_mode ? (cyc - last < 5) : (cyc - last != 5)) begin n_bad++; $display("FAIL b2b_gap got %0d exp %s5", cyc - last, rand_mode ? ">=" : ""); end
        end
        last = cyc; idx++;
        if (idx < n) in_data = words[idx];
      end
      in_valid = (idx < n) && (!rand_mode || ($urandom_range(0, 3) != 0));
    end
    in_valid = 1'b0;
    n_cmp++; if (idx != n) begin n_bad++; $display("FAIL b2b_accepted got %0d exp %0d", idx, n); end
    repeat (5) tick;
    n_cmp++; if (done_cnt - d0 != n) begin n_bad++; $display("FAIL b2b_done_count got %0d exp %0d", done_cnt - d0, n); end
    n_cmp++; if (tog_cnt - t0 != n) begin n_bad++; $display("FAIL b2b_toggles got %0d exp %0d", tog_cnt - t0, n); end
    n_cmp++; if (data_hold !== words[n-1]) begin n_bad++; $display("FAIL b2b_final_hold got %h exp %h", data_hold, words[n-1]); end
  endtask

  task automatic test_busy;
    int bad, t0, d0;
    loopback = 1'b0; ack_force = req_level;
    repeat (2) tick;
    t0 = tog_cnt;
    in_valid = 1'b1; in_data = 32'h1;
    tick;
    exp_req = ~exp_req; exp_hold = 32'h1; in_data = 32'hDEAD;
    bad = 0;
    repeat (20) begin
      tick;
      if (data_hold !== exp_hold || req_level !== exp_req || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL busy_hold bad_cycles got %0d exp 0", bad); end
    n_cmp++; if (tog_cnt - t0 != 1) begin n_bad++; $display("FAIL busy_toggles got %0d exp 1", tog_cnt - t0); end
    in_valid = 1'b0; ack_force = req_level;
    repeat (3) tick;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL busy_ack_early got %b exp 0", done); end
    tick;
    n_cmp++; if ({done, in_ready} !== 2'b11) begin n_bad++; $display("FAIL busy_ack_done got %b exp 11", {done, in_ready}); end
    d0 = done_cnt + 1;
    ack_force = ~ack_force;
    repeat (6) tick;
    n_cmp++; if (done_cnt != d0 || {in_ready, busy} !== 2'b10) begin n_bad++; $display("FAIL idle_ack_ignored got %0d/%b exp %0d/10", done_cnt, {in_ready, busy}, d0); end
    ack_force = req_level;
    repeat (4) tick;
    loopback = 1'b1;
  endtask

  task automatic test_midreset;
    int d0;
    loopback = 1'b1; in_valid = 1'b1; in_data = $urandom;
    tick;
    in_valid = 1'b0;
    repeat (2) tick;
    d0 = done_cnt;
    reset = 1'b0;
    #1;
    n_cmp++; if ({req_level, busy, in_ready} !== 3'b000 || data_hold !== '0) begin n_bad++; $display("FAIL midreset_state got %b/%h exp 000/0", {req_level, busy, in_ready}, data_hold); end
    repeat (3) tick;
    reset = 1'b1;
    tick;
    n_cmp++; if (done_cnt != d0 || in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_release got %0d/%b exp %0d/1", done_cnt, in_ready, d0); end
    exp_req = 1'b0; exp_hold = '0;
    test_loopback_single($urandom);
  endtask

  task automatic test_timeout;
    int acc, d0, bad, seen;
    loopback = 1'b0; ack_force = req_level;
    repeat (2) tick;
    d0 = done_cnt;
    in_valid = 1'b1; in_data = $urandom;
    tick;
    in_valid = 1'b0; exp_req = ~exp_req; exp_hold = in_data; acc = cyc;
`ifdef GTFRAW_SYNCER_TX_TIMEOUT_EN
    seen = 0;
    for (int c = 0; c < 40 && seen == 0; c++) begin tick; if (timeout_err === 1'b1) seen = 1; end
    n_cmp++; if (seen == 0 || cyc - acc != TO) begin n_bad++; $display("FAIL timeout_latency got %0d exp %0d", cyc - acc, TO); end
    n_cmp++; if ({in_ready, busy, req_level} !== {2'b10, exp_req} || data_hold !== exp_hold) begin n_bad++; $display("FAIL timeout_state got %b/%h exp %b/%h", {in_ready, busy, req_level}, data_hold, {2'b10, exp_req}, exp_hold); end
    tick;
    n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL timeout_pulse got %b exp 0", timeout_err); end
    ack_force = req_level;
    repeat (6) tick;
    n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL timeout_late_ack got %0d exp %0d", done_cnt, d0); end
`else
    bad = 0;
    repeat (40) begin tick; if (timeout_err !== 1'b0 || busy !== 1'b1) bad++; end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL no_timeout_wait got %0d exp 0", bad); end
    ack_force = req_level;
    repeat (5) tick;
    n_cmp++; if (done_cnt != d0 + 1) begin n_bad++; $display("FAIL no_timeout_done got %0d exp %0d", done_cnt, d0 + 1); end
`endif
    loopback = 1'b1;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; loopback = 1'b1; ack_force = 1'b0;
    test_reset;
    test_loopback_single(32'hA5A5_0001);
    test_loopback_single($urandom);
    test_back_to_back(1'b0, 4);
    test_back_to_back(1'b1, 8);
    test_busy;
    test_midreset;
    test_timeout;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end
endmodule
